// File: rtl/onehot_decoder_pipe_pkg.sv
// Shared types and helpers for the one-hot decoder pipeline.
// The storage state encoding is {skid valid, output valid}.
package onehot_decoder_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } store_state_t;

  // A single output line still needs a one-bit index, so index 1 can be flagged as out of range.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/onehot_decoder_pipe_decode.sv
// Combinational index-to-one-hot decode with an in-range flag; zero latency, no flow control.
// Bit order is optionally reversed to mirror an encoder that gives bit 0 the highest priority.
module onehot_decode_comb #(
  parameter int WIDTH             = 4,
  parameter int CL_WIDTH          = 2,
  parameter int LSB_HIGH_PRIORITY = 0
) (
  input  logic [CL_WIDTH-1:0] index,
  output logic [WIDTH-1:0]    onehot,
  output logic                in_range
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (index == CL_WIDTH'(i)) begin
        onehot[(LSB_HIGH_PRIORITY != 0) ? (WIDTH - 1 - i) : i] = 1'b1;
      end
    end
  end

  // Indices past WIDTH-1 match no line, so an empty select is exactly the out-of-range case.
  assign in_range = |onehot;

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered valid/ready index-to-one-hot decoder; 1 cycle latency, full throughput via skid register.
// Backpressure: s_ready is registered and drops only when both output and skid registers hold words.
module onehot_decoder_pipe
  import onehot_decoder_pipe_pkg::*;
#(
  parameter int WIDTH             = 4,
  parameter int CL_WIDTH          = idx_width(WIDTH),
  parameter int LSB_HIGH_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CL_WIDTH-1:0] s_index,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [WIDTH-1:0]    m_onehot,
  output logic [CL_WIDTH-1:0] m_index,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                err_range,
  output logic                err_sticky,
  input  logic                err_clear
);

  logic [WIDTH-1:0]    dec_onehot;
  logic                dec_in_range;
  logic                accept;
  logic                fwd;
  logic                drop;
  store_state_t        state;
  logic [WIDTH-1:0]    skid_onehot;
  logic [CL_WIDTH-1:0] skid_index;

  onehot_decode_comb #(
    .WIDTH             (WIDTH),
    .CL_WIDTH          (CL_WIDTH),
    .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
  ) u_decode (
    .index    (s_index),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  assign accept = s_valid && s_ready;
  assign fwd    = accept && dec_in_range;
  assign drop   = accept && !dec_in_range;

  // Dropped words never reach this block, so they cannot occupy a slot or move the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_EMPTY;
      m_valid     <= 1'b0;
      m_onehot    <= '0;
      m_index     <= '0;
      skid_onehot <= '0;
      skid_index  <= '0;
      s_ready     <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          s_ready <= 1'b1;
          if (fwd) begin
            m_onehot <= dec_onehot;
            m_index  <= s_index;
            m_valid  <= 1'b1;
            state    <= ST_ONE;
          end
        end

        ST_ONE: begin
          if (fwd && m_ready) begin
            m_onehot <= dec_onehot;
            m_index  <= s_index;
            s_ready  <= 1'b1;
          end else if (fwd) begin
            skid_onehot <= dec_onehot;
            skid_index  <= s_index;
            s_ready     <= 1'b0;
            state       <= ST_FULL;
          end else if (m_ready) begin
            // Clear the select lines so they are never active while invalid.
            m_valid  <= 1'b0;
            m_onehot <= '0;
            s_ready  <= 1'b1;
            state    <= ST_EMPTY;
          end else begin
            s_ready <= 1'b1;
          end
        end

        ST_FULL: begin
          if (m_ready) begin
            m_onehot <= skid_onehot;
            m_index  <= skid_index;
            s_ready  <= 1'b1;
            state    <= ST_ONE;
          end else begin
            s_ready <= 1'b0;
          end
        end

        default: begin
          state    <= ST_EMPTY;
          m_valid  <= 1'b0;
          m_onehot <= '0;
          s_ready  <= 1'b1;
        end
      endcase
    end
  end

  // A new error beats a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_range  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_range <= drop;
      if (drop) begin
        err_sticky <= 1'b1;
      end else if (err_clear) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed and randomised checks of onehot_decoder_pipe (WIDTH=5) plus a bit-reversed WIDTH=4 instance.
module tb_onehot_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [2:0] s_index = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [4:0] m_onehot;
  logic [2:0] m_index;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       err_range;
  logic       err_sticky;
  logic       err_clear = 1'b0;

  logic [1:0] r_s_index = '0;
  logic       r_s_valid = 1'b0;
  logic       r_s_ready;
  logic [3:0] r_m_onehot;
  logic [1:0] r_m_index;
  logic       r_m_valid;
  logic       r_m_ready = 1'b1;
  logic       r_err_range;
  logic       r_err_sticky;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  onehot_decoder_pipe #(.WIDTH(5), .CL_WIDTH(3), .LSB_HIGH_PRIORITY(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_index    (s_index),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_onehot   (m_onehot),
    .m_index    (m_index),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .err_range  (err_range),
    .err_sticky (err_sticky),
    .err_clear  (err_clear)
  );

  onehot_decoder_pipe #(.WIDTH(4), .CL_WIDTH(2), .LSB_HIGH_PRIORITY(1)) dut_r (
    .clk        (clk),
    .rst        (rst),
    .s_index    (r_s_index),
    .s_valid    (r_s_valid),
    .s_ready    (r_s_ready),
    .m_onehot   (r_m_onehot),
    .m_index    (r_m_index),
    .m_valid    (r_m_valid),
    .m_ready    (r_m_ready),
    .err_range  (r_err_range),
    .err_sticky (r_err_sticky),
    .err_clear  (1'b0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] stream_oh [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
  logic [2:0] q [$];
  logic       in_fire;
  logic       out_fire;
  logic [2:0] in_idx;
  logic [4:0] exp_oh;

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_onehot", m_onehot, 0);
    check("rst_m_index", m_index, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_err_range", err_range, 0);
    check("rst_err_sticky", err_sticky, 0);
    rst = 1'b0;
    check("rel_s_ready_low", s_ready, 0);
    step();
    check("rel_s_ready_high", s_ready, 1);
    check("rel_m_valid", m_valid, 0);

    // Back-to-back streaming
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_index = 3'(i);
      step();
      check("stream_valid", m_valid, 1);
      check("stream_onehot", m_onehot, stream_oh[i]);
      check("stream_index", m_index, i);
      check("stream_s_ready", s_ready, 1);
    end
    s_valid = 1'b0;
    step();
    check("stream_drain_valid", m_valid, 0);
    check("stream_drain_onehot", m_onehot, 0);

    // Backpressure into FULL
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_index = 3'd2;
    step();
    check("bp_one_onehot", m_onehot, 5'b00100);
    check("bp_one_s_ready", s_ready, 1);
    s_index = 3'd4;
    step();
    check("bp_full_s_ready", s_ready, 0);
    check("bp_full_onehot", m_onehot, 5'b00100);
    s_valid = 1'b0;
    step();
    check("bp_hold_onehot", m_onehot, 5'b00100);
    check("bp_hold_index", m_index, 2);
    check("bp_hold_s_ready", s_ready, 0);
    m_ready = 1'b1;
    step();
    check("bp_skid_onehot", m_onehot, 5'b10000);
    check("bp_skid_index", m_index, 4);
    check("bp_skid_s_ready", s_ready, 1);
    step();
    check("bp_empty_valid", m_valid, 0);
    check("bp_empty_onehot", m_onehot, 0);

    // Out-of-range drop between in-range words
    s_valid = 1'b1;
    s_index = 3'd1;
    step();
    check("oor_first_onehot", m_onehot, 5'b00010);
    check("oor_first_err", err_range, 0);
    s_index = 3'd6;
    step();
    check("oor_drop_valid", m_valid, 0);
    check("oor_drop_onehot", m_onehot, 0);
    check("oor_err_range", err_range, 1);
    check("oor_err_sticky", err_sticky, 1);
    s_index = 3'd3;
    step();
    check("oor_next_onehot", m_onehot, 5'b01000);
    check("oor_next_index", m_index, 3);
    check("oor_err_range_pulse", err_range, 0);
    check("oor_sticky_held", err_sticky, 1);
    err_clear = 1'b1;
    s_index = 3'd7;
    step();
    check("clr_vs_err_sticky", err_sticky, 1);
    check("clr_vs_err_range", err_range, 1);
    check("clr_vs_err_valid", m_valid, 0);
    s_valid = 1'b0;
    step();
    check("clr_sticky", err_sticky, 0);
    check("clr_err_range", err_range, 0);
    err_clear = 1'b0;

    // Bit-reversed mapping on the WIDTH=4 instance
    r_s_valid = 1'b1;
    r_s_index = 2'd0;
    step();
    check("rev_idx0_onehot", r_m_onehot, 4'b1000);
    check("rev_idx0_index", r_m_index, 0);
    r_s_index = 2'd3;
    step();
    check("rev_idx3_onehot", r_m_onehot, 4'b0001);
    check("rev_idx3_index", r_m_index, 3);
    r_s_valid = 1'b0;
    step();
    check("rev_drain_valid", r_m_valid, 0);
    check("rev_no_err", r_err_sticky, 0);

    // Reset with two words buffered and an error latched
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_index = 3'd5;
    step();
    check("mr_err_sticky", err_sticky, 1);
    s_index = 3'd0;
    step();
    s_index = 3'd1;
    step();
    check("mr_full_s_ready", s_ready, 0);
    check("mr_full_onehot", m_onehot, 5'b00001);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mr_async_valid", m_valid, 0);
    check("mr_async_onehot", m_onehot, 0);
    check("mr_async_sticky", err_sticky, 0);
    check("mr_async_s_ready", s_ready, 0);
    repeat (3) step();
    rst = 1'b0;
    check("mr_rel_s_ready_low", s_ready, 0);
    step();
    check("mr_rel_s_ready_high", s_ready, 1);
    m_ready = 1'b1;
    step();
    check("mr_no_stale_word", m_valid, 0);

    // Random traffic against an in-order scoreboard
    for (int c = 0; c < 4000; c++) begin
      s_valid  = 1'($urandom_range(0, 1));
      s_index  = 3'($urandom_range(0, 7));
      m_ready  = ($urandom_range(0, 3) != 0);
      in_fire  = s_valid && s_ready;
      in_idx   = s_index;
      out_fire = m_valid && m_ready;
      step();
      if (out_fire && q.size() != 0) begin
        void'(q.pop_front());
      end
      if (in_fire && in_idx < 3'd5) begin
        q.push_back(in_idx);
      end
      check("rnd_valid", m_valid, (q.size() != 0));
      check("rnd_s_ready", s_ready, (q.size() < 2));
      if (q.size() != 0) begin
        exp_oh = 5'b00001 << q[0];
        check("rnd_index", m_index, q[0]);
        check("rnd_onehot", m_onehot, exp_oh);
      end else begin
        check("rnd_idle_onehot", m_onehot, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
